// File: rtl/next_pc_bp.sv
// Fetch-stage next-PC unit: owns the fetch PC, predicts its successor and redirects on EX mispredict.
// Define NEXT_PC_BP_BTB_EN to build the direct-mapped BTB with 2-bit direction counters.
module next_pc_bp #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_is_branch_i,
  input  logic [2:0]      ex_next_pc_op_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [2:0]      OP_BR   = 3'b001;
  localparam logic [2:0]      OP_JAL  = 3'b010;
  localparam logic [2:0]      OP_JALR = 3'b011;
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic            actual_taken;
  logic [XLEN-1:0] actual_target;

  assign pc_plus4   = pc_q + FOUR;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;

  // EX resolution; unknown op codes fall through as sequential
  always_comb begin
    actual_taken  = 1'b0;
    actual_target = ex_pc_i + ex_imm_i;
    case (ex_next_pc_op_i)
      OP_BR, OP_JAL: actual_taken = 1'b1;
      OP_JALR: begin
        actual_taken  = 1'b1;
        actual_target = {ex_alu_result_i[XLEN-1:1], 1'b0};
      end
      default: actual_taken = 1'b0;
    endcase
  end

  assign redirect_pc_o = actual_taken ? actual_target : ex_pc_i + FOUR;
  assign redirect_o    = ex_valid_i &&
                         ((actual_taken != ex_pred_taken_i) ||
                          (actual_taken && (actual_target != ex_pred_target_i)));

`ifdef NEXT_PC_BP_BTB_EN
  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic            valid_q  [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0] target_q [BTB_ENTRIES];
  logic [1:0]      ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]  f_idx;
  logic [IDX-1:0]  ex_idx;
  logic            f_hit;
  logic            ex_hit;
  logic            is_jump;
  logic            train;

  assign f_idx  = pc_q[IDX+1:2];
  assign ex_idx = ex_pc_i[IDX+1:2];
  assign f_hit  = valid_q[f_idx] && (tag_q[f_idx] == pc_q[XLEN-1:IDX+2]);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_pc_i[XLEN-1:IDX+2]);

  assign pred_taken_o  = f_hit && ctr_q[f_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[f_idx] : pc_plus4;

  assign is_jump = (ex_next_pc_op_i == OP_JAL) || (ex_next_pc_op_i == OP_JALR);
  assign train   = ex_valid_i && (ex_is_branch_i || is_jump);

  // Lookup reads the pre-write entry; updates become visible next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (train) begin
      if (ex_hit) begin
        if (is_jump) begin
          ctr_q[ex_idx] <= 2'b11;
        end else if (actual_taken && (ctr_q[ex_idx] != 2'b11)) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
        end else if (!actual_taken && (ctr_q[ex_idx] != 2'b00)) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
        end
        if (actual_taken) begin
          target_q[ex_idx] <= actual_target;
        end
      end else if (actual_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_pc_i[XLEN-1:IDX+2];
        target_q[ex_idx] <= actual_target;
        ctr_q[ex_idx]    <= is_jump ? 2'b11 : 2'b10;
      end
    end
  end
`else
  logic unused_cfg;

  assign pred_taken_o  = 1'b0;
  assign pred_target_o = pc_plus4;
  assign unused_cfg    = ex_is_branch_i | (BTB_ENTRIES == 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else if (redirect_o) begin
      pc_q <= redirect_pc_o;
    end else if (!stall_i) begin
      pc_q <= pred_target_o;
    end
  end

endmodule
